// File: rtl/core_ctrl_if.sv
// core_ctrl_if: start/status handshake and instruction word between the core controller and its core.
interface core_ctrl_if;
    logic        start;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  kij;
    modport master (output start, ofifo_valid, input inst, busy, done, kij);
    modport slave (input start, ofifo_valid, output inst, busy, done, kij);
endinterface

// File: rtl/core_ctrl.sv
// core_ctrl: sequences weight load, activation stream, execute and OFIFO drain for every kernel position.
module core_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int len_nij = 36,
    parameter int len_kij = 9,
    parameter int w_base  = 1024,
    parameter int gap     = 2
) (
    input logic        clk,
    input logic        reset,
    core_ctrl_if.slave bus
);
    typedef enum logic [3:0] {IDLE, W_RD, W_LD, GAP1, A_RD, EXEC, DRAIN, GAP2, FIN} state_t;
    localparam logic [33:0] idle_inst = 34'h1_800C_0000;
    localparam logic [15:0] n_col     = 16'(col);
    localparam logic [15:0] n_nij     = 16'(len_nij);
    localparam logic [15:0] col_last  = 16'(col - 1);
    localparam logic [15:0] nij_last  = 16'(len_nij - 1);
    localparam logic [15:0] gap_last  = 16'(gap - 1);
    localparam logic [15:0] exec_last = 16'(len_nij + row + col - 1);
    localparam logic [3:0]  kij_last  = 4'(len_kij - 1);
    state_t      state_q, state_d;
    logic [3:0]  kij_q, kij_d;
    logic [15:0] i_q, i_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic        wr_pend_q, wr_pend_d;
    logic [33:0] inst_q, inst_d;
    logic        x_en, p_en, l0_rd, l0_wr, exec_en, load, of_rd, entry;
    logic [10:0] x_addr, p_addr;
    always_comb begin
        state_d = state_q;
        kij_d   = kij_q;
        x_en    = 1'b0;
        x_addr  = '0;
        l0_rd   = 1'b0;
        l0_wr   = 1'b0;
        exec_en = 1'b0;
        load    = 1'b0;
        of_rd   = 1'b0;
        p_en    = 1'b0;
        p_addr  = '0;
        case (state_q)
            IDLE: begin
                state_d = bus.start ? W_RD : IDLE;
                kij_d   = bus.start ? '0 : kij_q;
            end
            W_RD: begin
                x_en    = i_q < n_col;
                x_addr  = x_en ? 11'(w_base + int'(kij_q) * col + int'(i_q)) : '0;
                l0_wr   = i_q != '0;
                state_d = (i_q == n_col) ? W_LD : W_RD;
            end
            W_LD: begin
                l0_rd   = 1'b1;
                load    = 1'b1;
                state_d = (i_q == col_last) ? GAP1 : W_LD;
            end
            GAP1: state_d = (i_q == gap_last) ? A_RD : GAP1;
            A_RD: begin
                x_en    = i_q < n_nij;
                x_addr  = x_en ? i_q[10:0] : '0;
                l0_wr   = i_q != '0;
                state_d = (i_q == n_nij) ? EXEC : A_RD;
            end
            EXEC: begin
                exec_en = 1'b1;
                l0_rd   = i_q < n_nij;
                state_d = (i_q == exec_last) ? DRAIN : EXEC;
            end
            DRAIN: begin
                // each read is written back to pmem one cycle after it was issued
                of_rd   = bus.ofifo_valid && (rd_cnt_q < n_nij);
                p_en    = wr_pend_q;
                p_addr  = p_en ? 11'(int'(kij_q) * len_nij + int'(wr_cnt_q)) : '0;
                state_d = (wr_pend_q && wr_cnt_q == nij_last) ? GAP2 : DRAIN;
            end
            GAP2: begin
                state_d = (i_q != gap_last) ? GAP2 : (kij_q == kij_last) ? FIN : W_RD;
                kij_d   = (i_q == gap_last && kij_q != kij_last) ? kij_q + 4'd1 : kij_q;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        entry     = state_d != state_q;
        i_d       = entry ? '0 : i_q + 16'd1;
        rd_cnt_d  = entry ? '0 : rd_cnt_q + 16'(of_rd);
        wr_cnt_d  = entry ? '0 : wr_cnt_q + 16'(p_en);
        wr_pend_d = of_rd;
        inst_d    = {1'b0, !p_en, !p_en, p_addr, !x_en, 1'b1, x_addr, of_rd, 2'b00, l0_rd, l0_wr, exec_en, load};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            kij_q     <= '0;
            i_q       <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            wr_pend_q <= 1'b0;
            inst_q    <= idle_inst;
        end else begin
            state_q   <= state_d;
            kij_q     <= kij_d;
            i_q       <= i_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_pend_q <= wr_pend_d;
            inst_q    <= inst_d;
        end
    end
    assign bus.inst = inst_q;
    assign bus.busy = state_q != IDLE;
    assign bus.done = state_q == FIN;
    assign bus.kij  = kij_q;
endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: random-OFIFO-valid runs of core_ctrl checked against a transaction-level address/count model.
module tb_core_ctrl;
    localparam int row = 8, col = 8, len_nij = 36, len_kij = 9, w_base = 1024, gap = 2;
    localparam logic [33:0] idle_inst = 34'h1_800C_0000;
    logic clk = 1'b0;
    logic reset = 1'b1;
    core_ctrl_if bus ();
    core_ctrl #(.row(row), .col(col), .len_nij(len_nij), .len_kij(len_kij), .w_base(w_base), .gap(gap))
        dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    int n_cmp = 0, n_bad = 0;
    int exp_x[$];
    int p_next, n_load, n_exec, n_l0rd, n_l0wr, n_done;
    int rd_per[16], wr_per[16];
    logic [33:0] prev_inst;
    logic prev_done;
    bit running;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // expected xmem read order for a whole sequence: 8 weight words then 36 activations per kernel
    task automatic init_model();
        exp_x.delete();
        for (int k = 0; k < len_kij; k++) begin
            for (int j = 0; j < col; j++) exp_x.push_back(w_base + k * col + j);
            for (int j = 0; j < len_nij; j++) exp_x.push_back(j);
        end
        p_next = 0; n_load = 0; n_exec = 0; n_l0rd = 0; n_l0wr = 0; n_done = 0;
        rd_per = '{default: 0};
        wr_per = '{default: 0};
        prev_inst = idle_inst;
        prev_done = 1'b0;
        running = 1'b0;
    endtask
    task automatic monitor();
        logic [33:0] v;
        int e;
        v = bus.inst;
        chk("zero_bits", {v[33], v[5], v[4]}, 0);
        chk("l0_wr_after_xrd", v[2], !prev_inst[19]);
        chk("pmem_after_ofifo_rd", !v[32], prev_inst[6]);
        if (v[6]) begin
            chk("ofifo_rd_valid", bus.ofifo_valid, 1);
            rd_per[bus.kij]++;
        end
        if (!v[19]) begin
            if (exp_x.size() > 0) e = exp_x.pop_front();
            else e = -1;
            chk("xmem_wen", v[18], 1);
            chk("xmem_addr", v[17:7], e);
        end
        if (!v[32]) begin
            chk("pmem_wen", v[31], 0);
            chk("pmem_addr", v[30:20], p_next);
            chk("pmem_kij", bus.kij, p_next / len_nij);
            if (p_next / len_nij < 16) wr_per[p_next / len_nij]++;
            p_next++;
        end
        n_load += int'(v[0]);
        n_exec += int'(v[1]);
        n_l0rd += int'(v[3]);
        n_l0wr += int'(v[2]);
        if (bus.done) n_done++;
        if (running) begin
            if (prev_done) begin
                chk("busy_after_done", bus.busy, 0);
                running = 1'b0;
            end else chk("busy_running", bus.busy, 1);
        end
        prev_done = bus.done;
        prev_inst = v;
    endtask
    task automatic step(input bit rnd);
        @(posedge clk);
        #1;
        monitor();
        bus.ofifo_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask
    task automatic abort_seq();
        reset = 1'b1;
        #1;
        chk("abort_inst", bus.inst, idle_inst);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_kij", bus.kij, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        init_model();
        repeat (4) begin
            step(1'b1);
            chk("post_abort_idle", bus.inst, idle_inst);
            chk("post_abort_busy", bus.busy, 0);
        end
    endtask
    // mode 0: plain run, 1: start re-pulsed during EXEC of kij=2, 2: reset during EXEC of kij=3
    task automatic run_seq(input bit rnd, input int mode);
        int cyc;
        bit kick;
        init_model();
        running = 1'b1;
        bus.start = 1'b1;
        step(rnd);
        bus.start = 1'b0;
        cyc = 0;
        kick = 1'b0;
        while (running && cyc < 5000) begin
            if (mode == 1 && !kick && bus.inst[1] && bus.kij == 4'd2) begin
                bus.start = 1'b1;
                kick = 1'b1;
            end
            step(rnd);
            bus.start = 1'b0;
            cyc++;
            if (mode == 2 && bus.inst[1] && bus.kij == 4'd3) begin
                abort_seq();
                return;
            end
        end
        chk("seq_finished", running, 0);
        chk("idle_after_done", bus.inst, idle_inst);
        chk("done_count", n_done, 1);
        chk("xmem_all_read", exp_x.size(), 0);
        chk("pmem_total", p_next, len_kij * len_nij);
        for (int k = 0; k < len_kij; k++) begin
            chk("ofifo_rd_per_kij", rd_per[k], len_nij);
            chk("pmem_wr_per_kij", wr_per[k], len_nij);
        end
        chk("load_cycles", n_load, len_kij * col);
        chk("exec_cycles", n_exec, len_kij * (len_nij + row + col));
        chk("l0_rd_cycles", n_l0rd, len_kij * (col + len_nij));
        chk("l0_wr_cycles", n_l0wr, len_kij * (col + len_nij));
        if (mode == 1) chk("start_kick_applied", kick, 1);
    endtask
    initial begin
        bus.start = 1'b0;
        bus.ofifo_valid = 1'b1;
        init_model();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_inst", bus.inst, idle_inst);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_kij", bus.kij, 0);
        reset = 1'b0;
        step(1'b0);
        chk("idle_hold", bus.inst, idle_inst);
        run_seq(1'b0, 0);
        run_seq(1'b1, 0);
        run_seq(1'b0, 1);
        run_seq(1'b1, 2);
        run_seq(1'b1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/core_ctrl.md
CORE_CTRL -- requirements
Module: core_ctrl

Parameters (name, default, meaning)
- row, 8, PE array rows.
- col, 8, PE array columns and weight words per kernel.
- len_nij, 36, activation words per pass.
- len_kij, 9, kernel positions.
- w_base, 1024, xmem address of the kernel-0 weights; kernel k occupies w_base+k*col .. w_base+k*col+col-1.
- gap, 2, idle cycles between phases.

Interface
REQ-001 SHALL provide `clk`, input, 1 bit: single clock, rising-edge.
REQ-002 SHALL provide `reset`, input, 1 bit: asynchronous, active-high.
REQ-003 SHALL provide `start`, input, 1 bit: begins a full kij sequence when idle.
REQ-004 SHALL provide `ofifo_valid`, input, 1 bit: the core OFIFO holds readable data.
REQ-005 SHALL provide `inst`, output, 34 bits, drives the core instruction word. Bit fields:
- [33] acc
- [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem
- [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem
- [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd
- [3] l0_rd, [2] l0_wr, [1] execute, [0] load
REQ-006 SHALL provide `busy`, output, 1 bit: high from the start acceptance until done.
REQ-007 SHALL provide `done`, output, 1 bit: one-cycle pulse at the end of the sequence.
REQ-008 SHALL provide `kij`, output, 4 bits: index of the current kernel position.

Function
REQ-009 `inst` SHALL be registered; each field SHALL take the value decided for the current state one cycle later.
REQ-010 The idle `inst` value SHALL be 34'h1_800C_0000: CEN and WEN of both memories high, all other bits 0.
REQ-011 acc, ififo_wr and ififo_rd SHALL stay 0 at all times; accumulation is out of scope.
REQ-012 FSM states: IDLE, W_RD, W_LD, GAP1, A_RD, EXEC, DRAIN, GAP2, FIN.
REQ-013 IDLE SHALL go to W_RD with kij=0 on start=1; start SHALL be ignored in every other state.
REQ-014 W_RD SHALL last col+1 cycles.
- First col cycles: CEN_xmem=0, WEN_xmem=1, A_xmem=w_base+kij*col+i.
- Last col cycles: l0_wr=1, giving a 1-cycle SRAM read latency.
REQ-015 W_LD SHALL last col cycles with l0_rd=1 and load=1.
REQ-016 GAP1 and GAP2 SHALL each last `gap` cycles with the idle `inst` value.
REQ-017 A_RD SHALL last len_nij+1 cycles, as in REQ-014 but with A_xmem=i for i=0..len_nij-1.
REQ-018 EXEC SHALL last len_nij+row+col cycles.
- execute=1 throughout.
- l0_rd=1 for the first len_nij cycles only.
REQ-019 DRAIN: ofifo_rd=1 in a cycle SHALL require both ofifo_valid=1 and rd_cnt<len_nij.
- Each ofifo_rd SHALL produce, one cycle later, a pmem write: CEN_pmem=0, WEN_pmem=0, A_pmem=kij*len_nij+wr_cnt.
- DRAIN SHALL exit when wr_cnt reaches len_nij.
- DRAIN SHALL wait indefinitely while ofifo_valid=0.
REQ-020 After GAP2, if kij<len_kij-1, the FSM SHALL increment kij and go to W_RD; otherwise it SHALL go to FIN.
REQ-021 FIN SHALL assert done for one cycle, clear busy, and return to IDLE.
REQ-022 Counters i, rd_cnt and wr_cnt SHALL clear on every state entry.
REQ-023 The A_pmem and A_xmem fields SHALL be 11 bits; with the defaults the maximum A_pmem is 323 and the maximum A_xmem is 1095, so neither wraps.
REQ-024 busy SHALL equal 1 in every state except IDLE, and SHALL be 0 in the cycle after the FIN cycle.

Reset
REQ-025 reset=1 SHALL asynchronously force: state=IDLE, kij=0, all counters 0, inst=34'h1_800C_0000, busy=0, done=0.
REQ-026 reset asserted in any state SHALL abort the sequence with no further memory writes; a later start SHALL restart from kij=0.

Verification
REQ-027 Apply reset -> inst=34'h1_800C_0000, busy=0, done=0, kij=0.
REQ-028 start pulse with ofifo_valid tied to 1 -> the following hold:
- A_xmem sequence 1024..1031, then 0..35 for kij=0.
- pmem writes to addresses 0..323, each exactly once and in order.
- One done pulse; busy falls in the cycle after done.
REQ-029 At kij=8 -> W_RD addresses are 1088..1095 and DRAIN writes are 288..323.
REQ-030 ofifo_valid toggling pseudo-randomly -> the following hold:
- ofifo_rd is never high while ofifo_valid=0.
- Exactly 36 ofifo_rd and 36 pmem writes per kij.
- The sequence completes with one done pulse.
REQ-031 start re-pulsed during EXEC -> no effect: kij and the address sequence are unchanged, and only one done pulse occurs.
REQ-032 reset asserted mid-EXEC at kij=3 -> inst is idle immediately and busy=0; a new start begins W_RD at A_xmem=1024 with kij=0.
